// File: rtl/pe_load_ctrl.sv
// pe_load_ctrl: sequences one convolution pass on a single PE.
// Streams filter words then ifmap words from the global buffer into the PE,
// pulses conv_continue, waits for conv_done and reports done / error.
// Optional build macro: PE_LOAD_CTRL_STALL_CNT_EN enables the stall_cnt counter
// (otherwise stall_cnt is tied to zero).
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for start, op_stage=IDLE
// ST_LOAD_FLT  | reading filter words and broadcasting filter packets
// ST_ARM       | single cycle, pulses conv_continue
// ST_STREAM    | reading ifmap words through the holding slot, throttled by pe_full
// ST_WAIT_DONE | all ifmap words sent, waiting for conv_done
// ST_FINISH    | single cycle, pulses done
module pe_load_ctrl #(
    parameter int NUM_FILTER   = 4,
    parameter int FILTER_WORDS = 3,
    parameter int IFMAP_WORDS  = 57,
    parameter int IFMAP_BASE   = 12,
    parameter int TIMEOUT      = 4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        buf_rd_en,
    output logic [7:0]  buf_rd_addr,
    input  logic [31:0] buf_rd_data,
    output logic [1:0]  op_stage,
    output logic        filter_pkt_valid,
    output logic [4:0]  filter_pkt_idx,
    output logic [31:0] filter_pkt_data,
    output logic        ifmap_pkt_valid,
    output logic [4:0]  ifmap_pkt_idx,
    output logic [31:0] ifmap_pkt_data,
    input  logic        pe_full,
    input  logic        pe_error,
    input  logic        conv_done,
    output logic        conv_continue,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] stall_cnt
);

    localparam int FLT_TOTAL = NUM_FILTER * FILTER_WORDS;
    localparam int FLT_CW    = $clog2(FLT_TOTAL + 1);
    localparam int IFM_CW    = $clog2(IFMAP_WORDS + 1);
    localparam int TMR_W     = $clog2(TIMEOUT + 1);

    localparam logic [FLT_CW-1:0] FLT_END    = FLT_CW'(FLT_TOTAL);
    localparam logic [IFM_CW-1:0] IFM_END    = IFM_CW'(IFMAP_WORDS);
    localparam logic [IFM_CW-1:0] IFM_LAST   = IFM_CW'(IFMAP_WORDS - 1);
    localparam logic [2:0]        FW_LAST    = 3'(FILTER_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(TIMEOUT - 1);
    localparam logic [7:0]        IFM_BASE_A = 8'(IFMAP_BASE);

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_CONV = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_FLT,
        ST_ARM,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [FLT_CW-1:0]  flt_rd_cnt_q, flt_rd_cnt_d;
    logic [1:0]         rd_f_q, rd_f_d;
    logic [2:0]         rd_w_q, rd_w_d;
    logic [1:0]         pkt_f_q, pkt_f_d;
    logic [2:0]         pkt_w_q, pkt_w_d;
    logic               flt_vld_q, flt_vld_d;
    logic [IFM_CW-1:0]  ifm_rd_cnt_q, ifm_rd_cnt_d;
    logic [IFM_CW-1:0]  ifm_tx_cnt_q, ifm_tx_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               hold_vld_q, hold_vld_d;
    logic [31:0]        hold_q, hold_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               error_q, error_d;

    // A word is available either parked in the holding register or arriving
    // on buf_rd_data from last cycle's read; never both at once, so the pair
    // behaves as a single holding slot with no extra read in flight.
    logic        ifm_avail;
    logic [31:0] ifm_word;
    logic        ifm_xfer;

    assign ifm_avail     = hold_vld_q | rd_pend_q;
    assign ifm_word      = hold_vld_q ? hold_q : buf_rd_data;
    assign ifmap_pkt_idx = 5'd0;
    assign busy          = (state_q != ST_IDLE);
    assign error         = error_q;

    // Next-state, datapath updates and all combinational outputs.
    always_comb begin
        state_d      = state_q;
        flt_rd_cnt_d = flt_rd_cnt_q;
        rd_f_d       = rd_f_q;
        rd_w_d       = rd_w_q;
        pkt_f_d      = pkt_f_q;
        pkt_w_d      = pkt_w_q;
        flt_vld_d    = 1'b0;
        ifm_rd_cnt_d = ifm_rd_cnt_q;
        ifm_tx_cnt_d = ifm_tx_cnt_q;
        rd_pend_d    = 1'b0;
        hold_vld_d   = hold_vld_q;
        hold_d       = hold_q;
        tmr_d        = tmr_q;
        error_d      = error_q;

        buf_rd_en        = 1'b0;
        buf_rd_addr      = 8'd0;
        op_stage         = OP_IDLE;
        filter_pkt_valid = 1'b0;
        filter_pkt_idx   = 5'd0;
        filter_pkt_data  = 32'd0;
        ifmap_pkt_valid  = 1'b0;
        ifmap_pkt_data   = 32'd0;
        conv_continue    = 1'b0;
        done             = 1'b0;
        ifm_xfer         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD_FLT;
                    flt_rd_cnt_d = '0;
                    rd_f_d       = 2'd0;
                    rd_w_d       = 3'd0;
                    error_d      = 1'b0;
                end
            end

            ST_LOAD_FLT: begin
                op_stage = OP_LOAD;
                if (flt_rd_cnt_q < FLT_END) begin
                    buf_rd_en    = 1'b1;
                    buf_rd_addr  = 8'(flt_rd_cnt_q);
                    flt_vld_d    = 1'b1;
                    pkt_f_d      = rd_f_q;
                    pkt_w_d      = rd_w_q;
                    flt_rd_cnt_d = flt_rd_cnt_q + 1'b1;
                    if (rd_w_q == FW_LAST) begin
                        rd_w_d = 3'd0;
                        rd_f_d = rd_f_q + 2'd1;
                    end else begin
                        rd_w_d = rd_w_q + 3'd1;
                    end
                end
                if (flt_vld_q) begin
                    filter_pkt_valid = 1'b1;
                    filter_pkt_idx   = {pkt_f_q, pkt_w_q};
                    filter_pkt_data  = buf_rd_data;
                end
                // The packet for the final read is on the port this cycle.
                if (flt_vld_q && flt_rd_cnt_q == FLT_END) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                op_stage      = OP_CONV;
                conv_continue = 1'b1;
                state_d       = ST_STREAM;
                ifm_rd_cnt_d  = '0;
                ifm_tx_cnt_d  = '0;
                hold_vld_d    = 1'b0;
                tmr_d         = TMR_LOAD;
            end

            ST_STREAM: begin
                op_stage = OP_CONV;
                ifm_xfer = ifm_avail & ~pe_full;
                if (ifm_xfer) begin
                    ifmap_pkt_valid = 1'b1;
                    ifmap_pkt_data  = ifm_word;
                end
                if (ifm_rd_cnt_q < IFM_END && (!ifm_avail || ifm_xfer)) begin
                    buf_rd_en    = 1'b1;
                    buf_rd_addr  = IFM_BASE_A + 8'(ifm_rd_cnt_q);
                    rd_pend_d    = 1'b1;
                    ifm_rd_cnt_d = ifm_rd_cnt_q + 1'b1;
                end
                if (ifm_xfer) begin
                    hold_vld_d   = 1'b0;
                    ifm_tx_cnt_d = ifm_tx_cnt_q + 1'b1;
                end else if (rd_pend_q) begin
                    hold_d     = buf_rd_data;
                    hold_vld_d = 1'b1;
                end
                if (conv_done) begin
                    state_d = ST_FINISH;
                    if (!(ifm_xfer && ifm_tx_cnt_q == IFM_LAST)) begin
                        error_d = 1'b1;
                    end
                end else if (tmr_q == '0) begin
                    state_d = ST_FINISH;
                    error_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                    if (ifm_xfer && ifm_tx_cnt_q == IFM_LAST) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end

            ST_WAIT_DONE: begin
                op_stage = OP_CONV;
                if (conv_done) begin
                    state_d = ST_FINISH;
                end else if (tmr_q == '0) begin
                    state_d = ST_FINISH;
                    error_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A PE overflow aborts the pass from any active state.
        if (state_q != ST_IDLE && pe_error) begin
            error_d = 1'b1;
            if (state_q != ST_FINISH) begin
                state_d = ST_FINISH;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flt_rd_cnt_q <= '0;
            rd_f_q       <= 2'd0;
            rd_w_q       <= 3'd0;
            pkt_f_q      <= 2'd0;
            pkt_w_q      <= 3'd0;
            flt_vld_q    <= 1'b0;
            ifm_rd_cnt_q <= '0;
            ifm_tx_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_q       <= 32'd0;
            tmr_q        <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flt_rd_cnt_q <= flt_rd_cnt_d;
            rd_f_q       <= rd_f_d;
            rd_w_q       <= rd_w_d;
            pkt_f_q      <= pkt_f_d;
            pkt_w_q      <= pkt_w_d;
            flt_vld_q    <= flt_vld_d;
            ifm_rd_cnt_q <= ifm_rd_cnt_d;
            ifm_tx_cnt_q <= ifm_tx_cnt_d;
            rd_pend_q    <= rd_pend_d;
            hold_vld_q   <= hold_vld_d;
            hold_q       <= hold_d;
            tmr_q        <= tmr_d;
            error_q      <= error_d;
        end
    end

`ifdef PE_LOAD_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Count streaming cycles where a word is ready but the PE is full.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && start) begin
            stall_d = 16'd0;
        end else if (state_q == ST_STREAM && ifm_avail && pe_full && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/pe_load_ctrl.md
Name: pe_load_ctrl

Overview:
- Sequencer that runs one convolution pass on a single PE.
- Reads filter and ifmap words from the global buffer, drives op_stage, and broadcasts filter packets then ifmap packets. Ifmap packets are throttled by PE full.
- Pulses conv_continue, waits for conv_done and reports done/error to the top-level layer controller.
- Sits between the global buffer read port and the PE filter_packet / ifmap_packet / op_stage_in / conv_continue inputs.

Parameters:
- NUM_FILTER, 4, filters per PE.
- FILTER_WORDS, 3, 32-bit buffer words per filter (11 weights padded to 12 bytes).
- IFMAP_WORDS, 57, 32-bit ifmap words per pass (227 bytes, last byte zero-padded).
- IFMAP_BASE, 12, buffer word address of the first ifmap word.
- TIMEOUT, 4000, cycles allowed from entering STREAM to conv_done.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pass when idle
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  8  buffer word address
- buf_rd_data  in  32  read data, valid exactly 1 cycle after buf_rd_en
- op_stage  out  2  0=IDLE, 1=LOAD_FILTER, 2=CONV
- filter_pkt_valid  out  1  filter packet valid
- filter_pkt_idx  out  5  [2:0]=word index, [4:3]=filter index
- filter_pkt_data  out  32  four weight bytes
- ifmap_pkt_valid  out  1  ifmap packet valid
- ifmap_pkt_idx  out  5  always 0
- ifmap_pkt_data  out  32  byte0=lowest ifmap index
- pe_full  in  1  PE ifmap scratch pad full
- pe_error  in  1  PE overflow error
- conv_done  in  1  PE finished all outputs
- conv_continue  out  1  one-cycle pulse to PE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky; cleared by next accepted start
- stall_cnt  out  16  see Optional Feature

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-pass aborts immediately; the PE is not notified.
- IDLE: op_stage=0. start moves to LOAD_FLT next cycle. start in any other state is ignored.
- LOAD_FLT (op_stage=1):
  - Issues reads at addr 0..NUM_FILTER*FILTER_WORDS-1, one per cycle.
  - Each word is presented 1 cycle after its read, with filter_pkt_valid=1 and idx={f,w}, where addr=f*FILTER_WORDS+w.
  - No backpressure. Exactly 12 packets, on 12 consecutive cycles.
  - After the last packet, go to ARM.
- ARM: op_stage=2; conv_continue=1 for exactly this one cycle. Next state is STREAM.
- STREAM (op_stage=2): ifmap data flows through a single holding register.
  - Reads go to IFMAP_BASE+k, k=0..IFMAP_WORDS-1.
  - A read is issued when words remain AND (holding register empty OR a transfer occurs this cycle).
  - ifmap_pkt_valid = holding valid & ~pe_full.
  - Transfer = ifmap_pkt_valid. With pe_full low, one packet per cycle.
  - pe_full rising while holding is valid: data is held unchanged and no read is outstanding beyond the held word. No loss, no duplication.
  - After the 57th transfer, go to WAIT_DONE.
- WAIT_DONE: op_stage=2, wait for conv_done.
- Timeout: the counter starts at 0 on entering STREAM and increments every cycle in STREAM/WAIT_DONE.
  - If it reaches TIMEOUT without conv_done, set error and go to FINISH.
  - conv_done seen in STREAM before all words are sent: go to FINISH and set error.
- pe_error high in any non-IDLE state: set error and go to FINISH.
- FINISH: op_stage=0, done=1 for one cycle, then IDLE. done is also pulsed on error.

Optional Feature:
- Macro PE_LOAD_CTRL_STALL_CNT_EN.
- Defined: stall_cnt counts cycles in STREAM where holding is valid and pe_full=1. It saturates at 16'hFFFF, clears on accepted start, and holds its value after FINISH.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset then start, buffer word n = n, PE never full, conv_done 100 cycles after the last ifmap:
  - 12 filter packets idx {0,0}..{3,2}, data 0..11.
  - 1-cycle conv_continue.
  - 57 ifmap packets, data 12..68, on consecutive cycles.
  - done one cycle after conv_done; error=0.
- pe_full high for 5 cycles after the 10th ifmap packet: 11th packet data 22 appears once after release; 57 total, no duplicates; stall_cnt=5 when the feature is enabled.
- conv_done never asserts: error=1 and done pulse exactly TIMEOUT cycles after entering STREAM; op_stage returns to 0.
- pe_error pulses during LOAD_FLT: error=1, done pulse, no conv_continue, no ifmap packets.
- rst_n asserted mid-STREAM: all outputs 0 the same cycle. A new start runs a full clean pass with error=0.
- start pulsed while busy: ignored, and the packet counts are unchanged.
